queue_slice_serializer: RTL and testbench
=========================================

// Module: queue_slice_serializer
// PURPOSE
//  Width-down converter sitting directly downstream of the Queue FIFO. Pops one
//  BitWidth-bit word through Queue's output handshake and emits it as Ratio
//  consecutive SliceWidth-bit slices, least-significant slice first, on a
//  narrow REQ/ACK port. Flags the final slice of each word. Full throughput:
//  one slice per cycle with no bubble between words.
// PARAMETERS
//  BitWidth    32  width of the input word (matches the Queue BitWidth)
//  SliceWidth  8   width of each output slice; BitWidth % SliceWidth == 0
//  Ratio       BitWidth/SliceWidth (localparam; must be >= 2)
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           asynchronous reset, active-low
//  dInREQ     out  1           ready to take a word (drives Queue dOutREQ)
//  dInACK     in   1           input word valid (from Queue dOutACK)
//  dIN        in   BitWidth    input word (from Queue dOUT)
//  dOutACK    out  1           output slice valid
//  dOutREQ    in   1           downstream ready for a slice
//  dOUT       out  SliceWidth  current slice
//  dOutLast   out  1           high with the final slice of a word
//  Busy       out  1           a word is held (state SHIFT)
// BEHAVIOUR
//  - Input transfer = dInREQ && dInACK; output transfer = dOutACK && dOutREQ.
//  - Regs: state {EMPTY,SHIFT}, shreg[BitWidth-1:0], cnt[$clog2(Ratio)-1:0].
//  - Reset (rst low, async): state=EMPTY, cnt=0, shreg=0. While rst low:
//    dInREQ=0, dOutACK=0, dOUT=0, dOutLast=0, Busy=0. After release: dInREQ=1.
//  - EMPTY: dInREQ=1, dOutACK=0. On input transfer: shreg<=dIN, cnt<=0,
//    state<=SHIFT. Slice 0 valid the next cycle (1-cycle latency).
//  - SHIFT: dOutACK=1, dOUT=shreg[SliceWidth-1:0], dOutLast=(cnt==Ratio-1).
//    On output transfer with cnt<Ratio-1: shreg<=shreg>>SliceWidth, cnt<=cnt+1.
//    On output transfer with cnt==Ratio-1: if input transfer same cycle,
//    shreg<=dIN, cnt<=0, stay SHIFT; else state<=EMPTY, cnt<=0.
//  - dInREQ = (state==EMPTY) || (state==SHIFT && cnt==Ratio-1 && dOutREQ);
//    combinational path dOutREQ->dInREQ is intended (enables zero-bubble).
//  - dInACK without dInREQ: ignored, dIN not sampled.
//  - Backpressure: while dOutACK && !dOutREQ, dOUT/dOutLast/cnt/shreg hold.
//  - dOutACK never drops once raised until the slice transfers.
//  - cnt never exceeds Ratio-1; wraps to 0 only on the last-slice transfer.
//  - Reset mid-word: partial word discarded, no further slices emitted.
//  - Busy = (state==SHIFT).
// TESTING (BitWidth=32, SliceWidth=8)
//  1 Reset: rst low mid-stream -> dOutACK=0, dInREQ=0 immediately; after
//    release dInREQ=1, dOutACK=0.
//  2 Single word 0xAABBCCDD, dOutREQ=1 -> dOUT=DD,CC,BB,AA on 4 consecutive
//    cycles starting 1 cycle after accept; dOutLast=1 only with AA; then EMPTY.
//  3 Back-to-back 0x03020100, 0x07060504 with dInACK=1, dOutREQ=1 -> slices
//    00..07 on 8 consecutive cycles, dInREQ=1 on the AA-equivalent (03) cycle.
//  4 Backpressure: dOutREQ=0 for 3 cycles on slice CC -> dOUT=CC held,
//    dOutACK=1, dInREQ=0; resumes with BB after dOutREQ=1.
//  5 Last slice stalled (dOutREQ=0, dInACK=1) -> dInREQ=0, no word accepted
//    until the last slice transfers.
//  6 With Queue: push 4 words, drain -> 16 slices in FIFO/LSB-first order,
//    Queue BufferEmpty=1 and Busy=0 at end.

Source files
------------

// File: rtl/queue_slice_serializer_if.sv
// Handshake bundle for the slice serializer: wide word in from Queue, narrow slices out.
interface queue_slice_serializer_if #(
  parameter int BitWidth   = 32,
  parameter int SliceWidth = 8
);
  logic                  dInREQ;
  logic                  dInACK;
  logic [BitWidth-1:0]   dIN;
  logic                  dOutACK;
  logic                  dOutREQ;
  logic [SliceWidth-1:0] dOUT;
  logic                  dOutLast;
  logic                  Busy;

  modport master (
    output dInREQ, dOutACK, dOUT, dOutLast, Busy,
    input  dInACK, dIN, dOutREQ
  );

  modport slave (
    input  dInREQ, dOutACK, dOUT, dOutLast, Busy,
    output dInACK, dIN, dOutREQ
  );
endinterface

// File: rtl/queue_slice_serializer.sv
// Width-down converter: pops one word from Queue and emits it LSB slice first,
// one slice per cycle, with no bubble between consecutive words.
module queue_slice_serializer #(
  parameter int BitWidth   = 32,
  parameter int SliceWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  queue_slice_serializer_if.master bus
);
  localparam int Ratio = BitWidth / SliceWidth;
  localparam int CntW  = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Ratio - 1);

  typedef enum logic {EMPTY, SHIFT} state_t;

  state_t              state, stateNxt;
  logic [BitWidth-1:0] shreg, shregNxt;
  logic [CntW-1:0]     cnt, cntNxt;
  logic                atLast, inReq, outAck, inXfer, outXfer;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= stateNxt;
      shreg <= shregNxt;
      cnt   <= cntNxt;
    end
  end

  assign atLast  = (cnt == LastCnt);
  // The dOutREQ -> dInREQ path lets the next word load on the last-slice edge.
  assign inReq   = rst && ((state == EMPTY) || ((state == SHIFT) && atLast && bus.dOutREQ));
  assign outAck  = (state == SHIFT);
  assign inXfer  = inReq && bus.dInACK;
  assign outXfer = outAck && bus.dOutREQ;

  always_comb begin
    stateNxt = state;
    shregNxt = shreg;
    cntNxt   = cnt;
    unique case (state)
      EMPTY: begin
        if (inXfer) begin
          shregNxt = bus.dIN;
          cntNxt   = '0;
          stateNxt = SHIFT;
        end
      end
      SHIFT: begin
        if (outXfer) begin
          if (!atLast) begin
            shregNxt = shreg >> SliceWidth;
            cntNxt   = cnt + CntW'(1);
          end else if (inXfer) begin
            shregNxt = bus.dIN;
            cntNxt   = '0;
          end else begin
            cntNxt   = '0;
            stateNxt = EMPTY;
          end
        end
      end
      default: stateNxt = EMPTY;
    endcase
  end

  assign bus.dInREQ   = inReq;
  assign bus.dOutACK  = outAck;
  assign bus.dOUT     = shreg[SliceWidth-1:0];
  assign bus.dOutLast = outAck && atLast;
  assign bus.Busy     = (state == SHIFT);
endmodule

// File: tb/tb_queue_slice_serializer.sv
// Scoreboard bench: accepted words expand into expected slices, popped on each
// output transfer and compared in order.
module tb_queue_slice_serializer;
  localparam int BW = 32;
  localparam int SW = 8;
  localparam int R  = BW / SW;

  typedef struct packed {
    logic          last;
    logic [SW-1:0] data;
  } slice_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  queue_slice_serializer_if #(.BitWidth(BW), .SliceWidth(SW)) bus ();
  queue_slice_serializer #(.BitWidth(BW), .SliceWidth(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     checks = 0;
  int     fails  = 0;
  int     cyc    = 0;
  slice_t sb[$];
  int     popCyc[$];
  int     accCyc[$];

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // Monitor: all sampling on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (bus.dInREQ && bus.dInACK) begin
        for (int i = 0; i < R; i++) begin
          slice_t s;
          s.last = (i == R - 1);
          s.data = bus.dIN[i*SW +: SW];
          sb.push_back(s);
        end
        accCyc.push_back(cyc);
      end
      if (bus.dOutACK && bus.dOutREQ) begin
        if (sb.size() <= (bus.dInREQ && bus.dInACK ? R : 0)) begin
          chk("spuriousSlice", 1, 0);
        end else begin
          slice_t e;
          e = sb.pop_front();
          chk("sliceData", BW'(bus.dOUT), BW'(e.data));
          chk("sliceLast", BW'(bus.dOutLast), BW'(e.last));
          if (e.last) chk("reqOnLast", BW'(bus.dInREQ), 1);
          popCyc.push_back(cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the word on the port until it is accepted; dInACK is left high.
  task automatic sendWord(input logic [BW-1:0] w);
    bit ok = 0;
    bus.dIN    = w;
    bus.dInACK = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = bus.dInREQ;
      tick();
    end
    if (!ok) chk("acceptTimeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) chk("drainTimeout", 0, 1);
    tick();
  endtask

  logic [BW-1:0] fifo[$];

  initial begin
    bus.dInACK  = 1'b0;
    bus.dIN     = '0;
    bus.dOutREQ = 1'b1;
    #2;
    chk("rstInReq",  BW'(bus.dInREQ),  0);
    chk("rstOutAck", BW'(bus.dOutACK), 0);
    chk("rstDout",   BW'(bus.dOUT),    0);
    chk("rstBusy",   BW'(bus.Busy),    0);
    repeat (2) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("relInReq",  BW'(bus.dInREQ),  1);
    chk("relOutAck", BW'(bus.dOutACK), 0);
    tick();

    // Single word, full rate
    popCyc.delete(); accCyc.delete();
    sendWord(32'hAABBCCDD);
    bus.dInACK = 1'b0;
    drain();
    chk("singleCount", popCyc.size(), R);
    if (popCyc.size() == R && accCyc.size() == 1) begin
      chk("latency", popCyc[0] - accCyc[0], 1);
      chk("noBubble", popCyc[R-1] - popCyc[0], R - 1);
    end
    chk("idleBusy", BW'(bus.Busy), 0);

    // Back-to-back words
    popCyc.delete();
    sendWord(32'h03020100);
    sendWord(32'h07060504);
    bus.dInACK = 1'b0;
    drain();
    chk("b2bCount", popCyc.size(), 2 * R);
    if (popCyc.size() == 2 * R) chk("b2bNoBubble", popCyc[2*R-1] - popCyc[0], 2 * R - 1);

    // Backpressure on the second slice
    sendWord(32'hAABBCCDD);
    bus.dInACK = 1'b0;
    tick();
    bus.dOutREQ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bpDout",   BW'(bus.dOUT),    32'hCC);
      chk("bpOutAck", BW'(bus.dOutACK), 1);
      chk("bpInReq",  BW'(bus.dInREQ),  0);
      tick();
    end
    bus.dOutREQ = 1'b1;
    drain();

    // Last slice stalled with a word waiting
    sendWord(32'h44332211);
    bus.dInACK = 1'b0;
    repeat (R - 1) tick();
    bus.dOutREQ = 1'b0;
    bus.dIN     = 32'h88776655;
    bus.dInACK  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stallInReq", BW'(bus.dInREQ),   0);
      chk("stallLast",  BW'(bus.dOutLast), 1);
      chk("stallDout",  BW'(bus.dOUT),     32'h44);
      tick();
    end
    bus.dOutREQ = 1'b1;
    tick();
    bus.dInACK = 1'b0;
    drain();

    // Queue-fed stream with random downstream stalls
    for (int i = 0; i < 4; i++) fifo.push_back($urandom());
    for (int n = 0; n < 400 && fifo.size() != 0; n++) begin
      bus.dIN     = fifo[0];
      bus.dInACK  = 1'b1;
      bus.dOutREQ = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.dInREQ) void'(fifo.pop_front());
      tick();
    end
    bus.dInACK  = 1'b0;
    bus.dOutREQ = 1'b1;
    drain();
    chk("qFifoEmpty", fifo.size(), 0);
    chk("qBusy", BW'(bus.Busy), 0);

    // Reset mid-word discards the remainder
    sendWord(32'hDEADBEEF);
    bus.dInACK = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("midRstOutAck", BW'(bus.dOutACK),  0);
    chk("midRstInReq",  BW'(bus.dInREQ),   0);
    chk("midRstLast",   BW'(bus.dOutLast), 0);
    chk("midRstBusy",   BW'(bus.Busy),     0);
    sb.delete();
    tick();
    rst = 1'b1;
    popCyc.delete();
    repeat (3) begin
      @(negedge clk);
      chk("postRstInReq",  BW'(bus.dInREQ),  1);
      chk("postRstOutAck", BW'(bus.dOutACK), 0);
      tick();
    end
    chk("postRstNoSlices", popCyc.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
